// File: rtl/conv_frame_ctrl.sv
// Frame controller: zero-pads a raw IMG_W x IMG_H pixel stream by one pixel on every side for a conv engine.
// Optional macro CONV_FRAME_CTRL_STATS_EN adds the o_frames completed-frame counter.
module conv_frame_ctrl #(
  parameter int IMG_W     = 512,
  parameter int IMG_H     = 512,
  parameter int DRAIN_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_valid,
  input  logic [7:0]  i_x,
  output logic        o_ready,
  output logic        o_valid,
  output logic [7:0]  o_x,
  input  logic        i_ready,
  output logic        o_conv_reset,
  output logic        o_busy,
  output logic        o_done
`ifdef CONV_FRAME_CTRL_STATS_EN
  ,
  output logic [15:0] o_frames
`endif
);

  localparam int CW = $clog2(IMG_W + 2);
  localparam int RW = $clog2(IMG_H + 2);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W + 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] col, col_nx;
  logic [RW-1:0] row, row_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic          pad;
  logic          fire;

  assign pad = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);

  always_comb begin
    state_nx     = state;
    col_nx       = col;
    row_nx       = row;
    dcnt_nx      = dcnt;
    o_valid      = 1'b0;
    o_ready      = 1'b0;
    o_x          = '0;
    o_conv_reset = 1'b0;
    o_done       = 1'b0;
    o_busy       = (state != IDLE);
    fire         = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nx = CLEAR;
      end
      CLEAR: begin
        o_conv_reset = 1'b1;
        col_nx       = '0;
        row_nx       = '0;
        state_nx     = STREAM;
      end
      STREAM: begin
        // Border pixels are synthesised here; interior pixels pass straight through.
        if (pad) begin
          o_valid = 1'b1;
          fire    = i_ready;
        end else begin
          o_valid = i_valid;
          o_x     = i_x;
          o_ready = i_ready;
          fire    = i_valid && i_ready;
        end
        if (fire) begin
          if (col == COL_LAST) begin
            col_nx = '0;
            if (row == ROW_LAST) begin
              row_nx   = '0;
              dcnt_nx  = '0;
              state_nx = DRAIN;
            end else begin
              row_nx = row + RW'(1);
            end
          end else begin
            col_nx = col + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (i_ready) begin
          if (dcnt == DRAIN_LAST) begin
            dcnt_nx  = '0;
            state_nx = DONE;
          end else begin
            dcnt_nx = dcnt + DW'(1);
          end
        end
      end
      DONE: begin
        o_done   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      col   <= col_nx;
      row   <= row_nx;
      dcnt  <= dcnt_nx;
    end
  end

`ifdef CONV_FRAME_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      o_frames <= '0;
    end else if (state == DRAIN && state_nx == DONE) begin
      o_frames <= o_frames + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl (IMG_W=4, IMG_H=3, DRAIN_CYC=4); golden padded frame queued per frame.
// Also checks o_frames when CONV_FRAME_CTRL_STATS_EN is defined.
module tb_conv_frame_ctrl;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int D    = 4;
  localparam int PW   = W + 2;
  localparam int PH   = H + 2;
  localparam int NPIX = PW * PH;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_x = '0;
  logic       i_ready = 1'b0;
  logic       o_ready, o_valid, o_conv_reset, o_busy, o_done;
  logic [7:0] o_x;
`ifdef CONV_FRAME_CTRL_STATS_EN
  logic [15:0] o_frames;
`endif

  conv_frame_ctrl #(.IMG_W(W), .IMG_H(H), .DRAIN_CYC(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_valid      (i_valid),
    .i_x          (i_x),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_x          (o_x),
    .i_ready      (i_ready),
    .o_conv_reset (o_conv_reset),
    .o_busy       (o_busy),
    .o_done       (o_done)
`ifdef CONV_FRAME_CTRL_STATS_EN
    ,
    .o_frames     (o_frames)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int src_idx = 0;
  int xfers, consumed, n_clr, n_done;
  int frames_exp = 0;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] raw(input int k);
    return 8'(8'h21 + k * 5);
  endfunction

  // Drive inputs just after the falling edge and let combinational outputs settle.
  task automatic drive(input logic v, input logic r, input logic st);
    i_valid = v;
    i_ready = r;
    i_start = st;
    i_x     = v ? raw(src_idx) : 8'hEE;
    #1;
  endtask

  // Account for what the coming rising edge will transfer, then advance to the next falling edge.
  task automatic tick();
    if (o_conv_reset) n_clr++;
    if (o_done) n_done++;
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) check("extra_xfer", 1, 0);
      else check("pix", o_x, exp_q.pop_front());
      xfers++;
    end
    if (i_valid && o_ready) begin
      src_idx++;
      consumed++;
    end
    @(negedge clk);
  endtask

  task automatic check_frames();
`ifdef CONV_FRAME_CTRL_STATS_EN
    check("frames", o_frames, frames_exp);
`endif
  endtask

  task automatic frame_begin(input bit hold_start);
    int base;
    base = src_idx;
    xfers = 0; consumed = 0; n_clr = 0; n_done = 0;
    exp_q.delete();
    for (int rr = 0; rr < PH; rr++)
      for (int cc = 0; cc < PW; cc++)
        exp_q.push_back((rr == 0 || rr == PH-1 || cc == 0 || cc == PW-1) ? 8'h00
                        : raw(base + (rr-1)*W + (cc-1)));
    drive(1'b1, 1'b1, 1'b1);
    check("idle_busy", o_busy, 0);
    check("idle_valid", o_valid, 0);
    tick();
    drive(1'b1, 1'b1, hold_start);
    check("clr_pulse", o_conv_reset, 1);
    check("clr_valid", o_valid, 0);
    check("clr_busy", o_busy, 1);
    tick();
  endtask

  // mode 0: plain, 1: stalls in stream and drain, 2: upstream gaps, 3: i_start held high
  task automatic run_frame(input int mode);
    int cyc, stall, last_xfer_cyc, done_cyc, rr, cc;
    logic v, r;
    logic [7:0] held;
    held = '0;
    frame_begin(mode == 3);
    cyc = 0; stall = 0; last_xfer_cyc = -1; done_cyc = -1;
    while (n_done == 0 && cyc < 200) begin
      v = 1'b1;
      r = 1'b1;
      if (mode == 1 && xfers == 2*PW + 3 && stall < 3) r = 1'b0;
      if (mode == 1 && xfers == NPIX && stall >= 3 && stall < 5) r = 1'b0;
      if (mode == 2 && (cyc % 3) == 1) v = 1'b0;
      drive(v, r, mode == 3);
      if (xfers < NPIX) begin
        rr = xfers / PW;
        cc = xfers % PW;
        if (rr == 0 || rr == PH-1 || cc == 0 || cc == PW-1) begin
          check("pad_valid", o_valid, 1);
          check("pad_ready", o_ready, 0);
        end else if (!v) begin
          check("gap_valid", o_valid, 0);
        end
        if (!r) begin
          if (stall == 0) held = o_x;
          else check("stall_hold", o_x, held);
        end
      end else if (!o_done) begin
        check("drain_valid", o_valid, 0);
        check("drain_ready", o_ready, 0);
        check("drain_busy", o_busy, 1);
      end
      if (!r) stall++;
      if (o_done) done_cyc = cyc;
      tick();
      if (xfers == NPIX && last_xfer_cyc < 0) last_xfer_cyc = cyc;
      cyc++;
    end
    check("timeout", int'(cyc < 200), 1);
    check("done_cnt", n_done, 1);
    check("clr_cnt", n_clr, 1);
    check("xfers", xfers, NPIX);
    check("consumed", consumed, W*H);
    check("drain_lat", done_cyc - last_xfer_cyc, (mode == 1) ? D + 3 : D + 1);
    check("q_empty", exp_q.size(), 0);
    frames_exp++;
    drive(1'b0, 1'b1, 1'b0);
    check("post_busy", o_busy, 0);
    check_frames();
  endtask

  task automatic run_abort();
    int cyc;
    frame_begin(1'b0);
    cyc = 0;
    while (xfers < 2*PW && cyc < 100) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
      cyc++;
    end
    check("abort_reach", xfers, 2*PW);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    frames_exp = 0;
    n_done = 0;
    drive(1'b1, 1'b1, 1'b0);
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_clr", o_conv_reset, 0);
    check_frames();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    check("abort_nodone", n_done, 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1);
    check("reset_valid", o_valid, 0);
    check("reset_ready", o_ready, 0);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_clr", o_conv_reset, 0);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    check_frames();
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_abort();
    run_frame(3);
    run_frame(3);
    run_frame(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_frame_ctrl.md
CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 512, meaning unpadded image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 512, meaning unpadded image height in rows.
REQ-003 SHALL have parameter DRAIN_CYC, default 4, meaning conv pipeline drain beats counted after the last padded pixel.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_start  input  1  frame start request, sampled only in IDLE.
REQ-007 SHALL have port i_valid  input  1  upstream raw pixel valid.
REQ-008 SHALL have port i_x  input  8  upstream raw pixel.
REQ-009 SHALL have port o_ready  output  1  upstream ready, i.e. the raw pixel is consumed when i_valid && o_ready.
REQ-010 SHALL have port o_valid  output  1  padded pixel valid toward the conv engine.
REQ-011 SHALL have port o_x  output  8  padded pixel toward the conv engine.
REQ-012 SHALL have port i_ready  input  1  conv engine ready; a transfer occurs when o_valid && i_ready.
REQ-013 SHALL have port o_conv_reset  output  1  one-cycle clear pulse for the conv engine.
REQ-014 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port o_done  output  1  one-cycle frame-complete pulse.

Function
REQ-016 SHALL implement the FSM IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE.
REQ-017 IDLE SHALL move to CLEAR on i_start=1; i_start SHALL be ignored in all other states.
REQ-018 CLEAR SHALL last exactly 1 cycle with o_conv_reset=1 and o_valid=0; o_conv_reset SHALL be 0 in all other states.
REQ-019 STREAM SHALL emit (IMG_H+2) rows x (IMG_W+2) columns in raster order, tracked by a col counter (0..IMG_W+1) and a row counter (0..IMG_H+1).
REQ-020 Pad position (row 0, row IMG_H+1, col 0, col IMG_W+1): o_valid=1, o_x=0, o_ready=0.
REQ-021 Interior position: o_valid=i_valid, o_x=i_x, o_ready=i_ready (combinational pass-through, zero latency).
REQ-022 Counters SHALL advance only on a transfer; col wraps IMG_W+1 -> 0 and increments row.
REQ-023 A transfer at row IMG_H+1, col IMG_W+1 SHALL move to DRAIN with counters cleared.
REQ-024 DRAIN SHALL hold o_valid=0 and count cycles with i_ready=1, moving to DONE after DRAIN_CYC such cycles.
REQ-025 DONE SHALL last 1 cycle with o_done=1, then return to IDLE.
REQ-026 o_valid and o_ready SHALL be 0 in IDLE, CLEAR, DRAIN and DONE.
REQ-027 Stall (i_ready=0) SHALL hold o_x, position and state stable; upstream SHALL not be consumed.
REQ-028 Counter widths SHALL be $clog2(IMG_W+2) and $clog2(IMG_H+2) bits.

Reset
REQ-029 On reset the FSM SHALL enter IDLE, all counters SHALL be 0, and o_valid, o_ready, o_busy, o_done and o_conv_reset SHALL be 0 on the next cycle.
REQ-030 Reset mid-frame SHALL abandon the frame without an o_done pulse; the next i_start SHALL begin a full frame from row 0.

Configuration
REQ-031 Macro CONV_FRAME_CTRL_STATS_EN defined: add output o_frames  16 bits, a count of DONE entries, reset to 0 and wrapping 0xFFFF -> 0.
REQ-032 Macro CONV_FRAME_CTRL_STATS_EN undefined: o_frames port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 IMG_W=4, IMG_H=3, i_valid=1 and i_ready=1 always, pulse i_start -> 1 o_conv_reset cycle, then 30 transfers with 12 raw pixels consumed in order, then 4 drain cycles, then o_done for 1 cycle.
REQ-034 Same setup, i_ready low for 3 cycles at row 2 col 3 -> o_x and position held, no raw pixel lost or duplicated.
REQ-035 i_valid low during interior pixels -> o_valid=0 there and pad pixels unaffected, so the output stream matches a golden padded frame.
REQ-036 Reset asserted at row 2 -> next cycle IDLE with outputs 0 and no o_done; a new i_start yields a complete 30-transfer frame.
REQ-037 i_start held high during STREAM -> no restart; back-to-back frames each produce 1 o_conv_reset and 1 o_done; with STATS_EN, o_frames=2.
